// File: rtl/pc_flag_unit_if.sv
// ============================================================================
//  Module      : pc_flag_unit_if
//  Description : Decode/flag inputs and PC/flag/status outputs of pc_flag_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_flag_unit_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic            halt_req;
    logic            stall;
    logic            flag_we;
    logic            co_in;
    logic            z_in;
    logic            neg_in;
    logic            jump_abs;
    logic            branch_rel;
    logic [1:0]      cond_sel;
    logic [7:0]      offset;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            ci;
    logic            z_flag;
    logic            neg_flag;
    logic            running;
    logic            done;
    logic            taken;
    logic [15:0]     cycle_ct;

    modport master (
        output start, halt_req, stall, flag_we, co_in, z_in, neg_in,
               jump_abs, branch_rel, cond_sel, offset, target,
        input  pc, ci, z_flag, neg_flag, running, done, taken, cycle_ct
    );

    modport slave (
        input  start, halt_req, stall, flag_we, co_in, z_in, neg_in,
               jump_abs, branch_rel, cond_sel, offset, target,
        output pc, ci, z_flag, neg_flag, running, done, taken, cycle_ct
    );
endinterface

`default_nettype wire

// File: rtl/pc_flag_unit.sv
// ============================================================================
//  Module      : pc_flag_unit
//  Description : Flag latch, program counter with jump/branch select and
//                IDLE/RUN/HALT sequencer with saturating RUN-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_flag_unit #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0
) (
    input  wire logic         CLK,
    input  wire logic         rst_n,
    pc_flag_unit_if.slave     bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    localparam logic [PC_W-1:0] c_START = PC_W'(START_ADDR);

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_ci;
    logic            r_z;
    logic            r_neg;
    logic [15:0]     r_cycle_ct;

    logic            w_running;
    logic            w_cond;
    logic            w_advance;
    logic [PC_W-1:0] w_offset_ext;
    logic [PC_W-1:0] w_pc_next;

    assign w_running    = (r_state == c_RUN);
    assign w_advance    = w_running & ~bus.halt_req & ~bus.stall;
    assign w_offset_ext = PC_W'($signed(bus.offset));

    // Conditions test the flags latched before this edge, never co_in/z_in/neg_in.
    always_comb begin
        w_cond = 1'b1;
        case (bus.cond_sel)
            2'b00:   w_cond = 1'b1;
            2'b01:   w_cond = r_z;
            2'b10:   w_cond = r_neg;
            default: w_cond = r_ci;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        if (w_advance) begin
            if (bus.jump_abs)
                w_pc_next = bus.target;
            else if (bus.branch_rel && w_cond)
                w_pc_next = r_pc + w_offset_ext;
            else
                w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_pc       <= c_START;
            r_ci       <= 1'b0;
            r_z        <= 1'b0;
            r_neg      <= 1'b0;
            r_cycle_ct <= 16'd0;
        end else begin
            case (r_state)
                c_RUN: begin
                    r_pc <= w_pc_next;
                    // Flag writes are gated by stall only; a halting op still updates them.
                    if (!bus.stall && bus.flag_we) begin
                        r_ci  <= bus.co_in;
                        r_z   <= bus.z_in;
                        r_neg <= bus.neg_in;
                    end
                    if (r_cycle_ct != 16'hFFFF)
                        r_cycle_ct <= r_cycle_ct + 16'd1;
                    if (bus.halt_req)
                        r_state <= c_HALT;
                end
                c_IDLE, c_HALT: begin
                    if (bus.start) begin
                        r_state    <= c_RUN;
                        r_pc       <= c_START;
                        r_ci       <= 1'b0;
                        r_z        <= 1'b0;
                        r_neg      <= 1'b0;
                        r_cycle_ct <= 16'd0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.pc       = r_pc;
    assign bus.ci       = r_ci;
    assign bus.z_flag   = r_z;
    assign bus.neg_flag = r_neg;
    assign bus.running  = w_running;
    assign bus.done     = (r_state == c_HALT);
    assign bus.cycle_ct = r_cycle_ct;
    assign bus.taken    = w_advance & (bus.jump_abs | (bus.branch_rel & w_cond));

endmodule

`default_nettype wire
